// File: rtl/paula_ipl_sequencer.sv
// Merges Paula, expansion and NMI interrupt levels, glitch-filters the result on
// clk7_en, and sequences the 68k interrupt-acknowledge cycle with autovectors.
module paula_ipl_sequencer #(
   parameter int FILTER_LEN = 2,
   parameter int ACK_DELAY  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk7_en,
   input  logic [2:0] ipl_in,
   input  logic [2:0] ext_ipl_in,
   input  logic       nmi,
   input  logic       iack_req,
   input  logic [2:0] iack_level,
   output logic [2:0] _ipl_out,
   output logic [2:0] pending_level,
   output logic       iack_done,
   output logic [7:0] vector,
   output logic       spurious
);

   localparam logic [4:0] FLEN5 = 5'(FILTER_LEN);
   localparam logic [3:0] FLEN4 = 4'(FILTER_LEN);
   localparam logic [3:0] ADLY4 = 4'(ACK_DELAY);
   localparam logic [7:0] VEC_BASE = 8'h18;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   logic [2:0] paula_lvl, ext_lvl, merged;
   logic [2:0] cand_q, cand_d, level_q, level_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] cnt_inc;
   state_t     state_q, state_d;
   logic [3:0] dcnt_q, dcnt_d;
   logic       done_q, done_d;
   logic [7:0] vector_q, vector_d;
   logic       spur_q, spur_d;
   logic       spur_now;

   assign paula_lvl = ~ipl_in;
   assign ext_lvl   = ~ext_ipl_in;
   assign merged    = nmi ? 3'd7 : ((paula_lvl > ext_lvl) ? paula_lvl : ext_lvl);

   // Filter: a level is forwarded only after FILTER_LEN consecutive matching enable edges
   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      cnt_inc = {1'b0, cnt_q} + 5'd1;
      if (clk7_en) begin
         if (merged != cand_q) begin
            cand_d = merged;
            cnt_d  = 4'd1;
            if (FILTER_LEN == 1) level_d = merged;
         end else if (cnt_inc >= FLEN5) begin
            cnt_d   = FLEN4;
            level_d = cand_q;
         end else begin
            cnt_d = cnt_inc[3:0];
         end
      end
   end

   assign spur_now = (iack_level == 3'd0) || (iack_level > level_q);

   always_comb begin
      state_d  = state_q;
      dcnt_d   = dcnt_q;
      done_d   = done_q;
      vector_d = vector_q;
      spur_d   = spur_q;
      if (clk7_en) begin
         case (state_q)
            S_IDLE: begin
               if (iack_req) begin
                  spur_d   = spur_now;
                  vector_d = spur_now ? VEC_BASE : VEC_BASE + {5'b0, iack_level};
                  dcnt_d   = ADLY4;
                  state_d  = S_WAIT;
               end
            end
            S_WAIT: begin
               // An abandoned cycle keeps the captured vector for inspection
               if (!iack_req) begin
                  state_d = S_IDLE;
               end else if (dcnt_q == 4'd0) begin
                  state_d = S_ACK;
                  done_d  = 1'b1;
               end else begin
                  dcnt_d = dcnt_q - 4'd1;
               end
            end
            S_ACK: begin
               if (!iack_req) begin
                  done_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand_q   <= 3'd0;
         cnt_q    <= 4'd0;
         level_q  <= 3'd0;
         state_q  <= S_IDLE;
         dcnt_q   <= 4'd0;
         done_q   <= 1'b0;
         vector_q <= 8'h00;
         spur_q   <= 1'b0;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         state_q  <= state_d;
         dcnt_q   <= dcnt_d;
         done_q   <= done_d;
         vector_q <= vector_d;
         spur_q   <= spur_d;
      end
   end

   assign _ipl_out      = ~level_q;
   assign pending_level = level_q;
   assign iack_done     = done_q;
   assign vector        = vector_q;
   assign spurious      = spur_q;

endmodule

// File: tb/tb_paula_ipl_sequencer.sv
// Bench for paula_ipl_sequencer: directed scenarios plus random stimulus against a
// history-based reference model of the filter and acknowledge sequence.
module tb_paula_ipl_sequencer;

   localparam int FLEN = 2;
   localparam int ADLY = 3;

   logic       clk;
   logic       reset;
   logic       clk7_en;
   logic [2:0] ipl_in;
   logic [2:0] ext_ipl_in;
   logic       nmi;
   logic       iack_req;
   logic [2:0] iack_level;
   logic [2:0] _ipl_out;
   logic [2:0] pending_level;
   logic       iack_done;
   logic [7:0] vector;
   logic       spurious;

   paula_ipl_sequencer #(.FILTER_LEN(FLEN), .ACK_DELAY(ADLY)) dut (
      .clk(clk), .reset(reset), .clk7_en(clk7_en),
      .ipl_in(ipl_in), .ext_ipl_in(ext_ipl_in), .nmi(nmi),
      .iack_req(iack_req), .iack_level(iack_level),
      ._ipl_out(_ipl_out), .pending_level(pending_level),
      .iack_done(iack_done), .vector(vector), .spurious(spurious)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state
   int m_hist[$];
   int m_level;
   bit m_active;
   int m_age;
   bit m_done;
   int m_vec;
   bit m_spur;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_hist.delete();
      m_level  = 0;
      m_active = 1'b0;
      m_age    = 0;
      m_done   = 1'b0;
      m_vec    = 0;
      m_spur   = 1'b0;
   endfunction

   function automatic void m_edge();
      int a, b, mg, il;
      bit same;
      a  = 7 - int'(ipl_in);
      b  = 7 - int'(ext_ipl_in);
      mg = nmi ? 7 : ((a > b) ? a : b);
      il = int'(iack_level);
      // acknowledge decisions use the level visible before this edge
      if (!m_active) begin
         if (iack_req) begin
            m_active = 1'b1;
            m_age    = 0;
            m_spur   = (il == 0) || (il > m_level);
            m_vec    = m_spur ? 24 : 24 + il;
         end
      end else if (!iack_req) begin
         m_active = 1'b0;
         m_done   = 1'b0;
      end else begin
         m_age++;
         if (m_age >= ADLY + 1) m_done = 1'b1;
      end
      m_hist.push_back(mg);
      if (m_hist.size() > FLEN) void'(m_hist.pop_front());
      if (m_hist.size() == FLEN) begin
         same = 1'b1;
         foreach (m_hist[i]) if (m_hist[i] != mg) same = 1'b0;
         if (same) m_level = mg;
      end
   endfunction

   task automatic check_all();
      chk("ipl_out", 32'(_ipl_out), 32'(7 - m_level));
      chk("pending", 32'(pending_level), 32'(m_level));
      chk("done", 32'(iack_done), 32'(m_done));
      chk("vector", 32'(vector), 32'(m_vec));
      chk("spurious", 32'(spurious), 32'(m_spur));
   endtask

   // Called at a negedge; inputs are already set for the coming posedge
   task automatic tick(input bit en);
      clk7_en = en;
      @(posedge clk);
      if (reset) m_reset();
      else if (en) m_edge();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      reset = 1'b1; clk7_en = 1'b0; ipl_in = 3'b111; ext_ipl_in = 3'b111;
      nmi = 1'b0; iack_req = 1'b0; iack_level = 3'd0;
      m_reset();
      @(negedge clk);
      chk("rst_ipl", 32'(_ipl_out), 'h7);
      chk("rst_vec", 32'(vector), 'h0);
      tick(1'b1);
      reset = 1'b0;
      repeat (6) tick(1'b1);
      chk("idle_ipl", 32'(_ipl_out), 'h7);
      chk("idle_done", 32'(iack_done), 'h0);

      // Level 5 held, with enable gaps between edges
      ipl_in = 3'b010;
      tick(1'b1);
      chk("flt_e1", 32'(_ipl_out), 'h7);
      repeat (3) tick(1'b0);
      chk("flt_gap", 32'(_ipl_out), 'h7);
      tick(1'b1);
      chk("flt_e2", 32'(_ipl_out), 'h2);

      // Back to 0, then a single-edge level-5 pulse is dropped
      ipl_in = 3'b111;
      repeat (3) tick(1'b1);
      chk("flt_zero", 32'(pending_level), 'h0);
      ipl_in = 3'b010;
      tick(1'b1);
      ipl_in = 3'b111;
      repeat (4) tick(1'b1);
      chk("flt_pulse", 32'(_ipl_out), 'h7);

      // Merge priority and NMI
      ipl_in = 3'b100; ext_ipl_in = 3'b001;
      repeat (2) tick(1'b1);
      chk("merge_max", 32'(pending_level), 'h6);
      nmi = 1'b1;
      tick(1'b1);
      chk("nmi_e1", 32'(pending_level), 'h6);
      tick(1'b1);
      chk("nmi_e2", 32'(pending_level), 'h7);
      nmi = 1'b0; ext_ipl_in = 3'b111;

      // Normal acknowledge at level 4
      ipl_in = 3'b011;
      repeat (3) tick(1'b1);
      chk("lvl4", 32'(pending_level), 'h4);
      iack_level = 3'd4; iack_req = 1'b1;
      tick(1'b1);
      for (int i = 1; i <= ADLY; i++) begin
         tick(1'b1);
         chk("ack_wait", 32'(iack_done), 'h0);
      end
      tick(1'b1);
      chk("ack_done", 32'(iack_done), 'h1);
      chk("ack_vec", 32'(vector), 'h1C);
      chk("ack_spur", 32'(spurious), 'h0);
      iack_req = 1'b0;
      tick(1'b1);
      chk("ack_drop", 32'(iack_done), 'h0);

      // Spurious acknowledges at level 2
      ipl_in = 3'b101;
      repeat (3) tick(1'b1);
      iack_level = 3'd5; iack_req = 1'b1;
      repeat (ADLY + 2) tick(1'b1);
      chk("spur_hi_vec", 32'(vector), 'h18);
      chk("spur_hi_flag", 32'(spurious), 'h1);
      chk("spur_hi_done", 32'(iack_done), 'h1);
      iack_req = 1'b0;
      tick(1'b1);
      iack_level = 3'd0; iack_req = 1'b1;
      repeat (ADLY + 2) tick(1'b1);
      chk("spur_zero_vec", 32'(vector), 'h18);
      chk("spur_zero_flag", 32'(spurious), 'h1);
      iack_req = 1'b0;
      tick(1'b1);

      // Abort during the delay
      iack_level = 3'd2; iack_req = 1'b1;
      repeat (2) tick(1'b1);
      iack_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1'b1);
         chk("abort_done", 32'(iack_done), 'h0);
      end
      chk("abort_vec", 32'(vector), 'h1A);

      // Asynchronous reset while acknowledged
      iack_req = 1'b1;
      repeat (ADLY + 2) tick(1'b1);
      chk("pre_rst_done", 32'(iack_done), 'h1);
      reset = 1'b1;
      #1;
      chk("arst_done", 32'(iack_done), 'h0);
      chk("arst_ipl", 32'(_ipl_out), 'h7);
      m_reset();
      iack_req = 1'b0;
      ipl_in = 3'b111;
      @(negedge clk);
      tick(1'b1);
      reset = 1'b0;

      // Random stimulus
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 3) == 0) ipl_in = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) ext_ipl_in = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 29) == 0) nmi = ~nmi;
         if ($urandom_range(0, 7) == 0) begin
            iack_req = ~iack_req;
            if (iack_req) iack_level = 3'($urandom_range(0, 7));
         end
         tick($urandom_range(0, 9) < 7);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
